l2_cfi_instr_responder: RTL and testbench

- Slave (responder) end of the CFI-widened TCDM instruction interface: accepts fetch requests from the FC core's instruction master and returns CFI_INSTR_WIDTH-bit instruction words.
- Sits between the SoC interconnect instruction port and one single-port L2 SRAM macro with fixed read latency.
- Checks address range and access type, and generates ordered error responses on r_opc.

---
 rtl/l2_cfi_resp_pkg.sv | 19 +
 rtl/l2_cfi_stall_lfsr.sv | 28 ++
 rtl/l2_cfi_instr_responder.sv | 90 +++++++++
 tb/tb_l2_cfi_instr_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/l2_cfi_resp_pkg.sv
// Shared types and constants for the L2 CFI instruction responder.
package l2_cfi_resp_pkg;

    typedef struct packed {
        logic valid;
        logic err;
    } resp_stage_t;

    localparam logic [7:0]  LFSR_SEED = 8'hA5;
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam logic [1:0]  MAX_STALL = 2'd3;
    localparam int unsigned ERR_CNT_W = 16;

    // Fibonacci feedback bit for x^8+x^6+x^5+x^4+1 (shift-left form).
    function automatic logic lfsr_feedback(input logic [7:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/l2_cfi_stall_lfsr.sv
// Pseudo-random grant stall source. Denials are capped at MAX_STALL in a row
// so a persistent requester always makes progress.
module l2_cfi_stall_lfsr
    import l2_cfi_resp_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic stall_o
);

    logic [7:0] lfsr;
    logic [1:0] stall_cnt;

    assign stall_o = (lfsr[1:0] == 2'b00) && (stall_cnt < MAX_STALL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr      <= LFSR_SEED;
            stall_cnt <= '0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_feedback(lfsr)};
            if (req_i && stall_o) stall_cnt <= stall_cnt + 2'd1;
            else                  stall_cnt <= '0;
        end
    end

endmodule

// File: rtl/l2_cfi_instr_responder.sv
// Read-only TCDM instruction responder in front of one fixed-latency L2 SRAM.
// Define L2_RESP_STALL_EN to enable pseudo-random grant stalls.
module l2_cfi_instr_responder
    import l2_cfi_resp_pkg::*;
#(
    parameter int unsigned CFI_INSTR_WIDTH = 32,
    parameter int unsigned MEM_ADDR_WIDTH  = 14,
    parameter logic [31:0] BASE_ADDR       = 32'h1C00_0000,
    parameter int unsigned MEM_LATENCY     = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic [31:0]                add_i,
    input  logic                       wen_i,
    input  logic [31:0]                wdata_i,
    input  logic [3:0]                 be_i,
    output logic                       gnt_o,
    output logic                       r_valid_o,
    output logic [CFI_INSTR_WIDTH-1:0] r_rdata_o,
    output logic                       r_opc_o,
    output logic                       mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic [CFI_INSTR_WIDTH-1:0] mem_rdata_i,
    output logic [15:0]                err_cnt_o
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
        $error("l2_cfi_instr_responder: MEM_LATENCY must be in 1..4");
    end

    logic stall;
`ifdef L2_RESP_STALL_EN
    l2_cfi_stall_lfsr u_stall (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .stall_o (stall)
    );
`else
    assign stall = 1'b0;
`endif

    assign gnt_o = req_i & ~stall & ~rst_i;

    // 33-bit compare so BASE_ADDR near the top of the map cannot wrap the bound.
    logic [32:0] add_ext, base_ext, limit_ext;
    logic        in_range, ok;
    logic [31:0] offset;

    assign add_ext   = {1'b0, add_i};
    assign base_ext  = {1'b0, BASE_ADDR};
    assign limit_ext = base_ext + (33'd4 << MEM_ADDR_WIDTH);
    assign in_range  = (add_ext >= base_ext) && (add_ext < limit_ext);
    assign ok        = in_range & wen_i;
    assign offset    = add_i - BASE_ADDR;

    assign mem_req_o  = gnt_o & ok;
    assign mem_addr_o = mem_req_o ? offset[MEM_ADDR_WIDTH+1:2] : '0;

    logic unused_inputs;
    assign unused_inputs = ^{wdata_i, be_i, offset[31:MEM_ADDR_WIDTH+2], offset[1:0]};

    resp_stage_t pipe [MEM_LATENCY];
    resp_stage_t resp;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MEM_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: gnt_o, err: gnt_o & ~ok};
            for (int unsigned i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign resp      = pipe[MEM_LATENCY-1];
    assign r_valid_o = resp.valid;
    assign r_opc_o   = resp.valid & resp.err;
    assign r_rdata_o = (resp.valid & ~resp.err) ? mem_rdata_i : '0;

    logic [ERR_CNT_W-1:0] err_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          err_cnt <= '0;
        else if (r_opc_o && err_cnt != '1)  err_cnt <= err_cnt + ERR_CNT_W'(1);
    end

    assign err_cnt_o = err_cnt;

endmodule

// File: tb/tb_l2_cfi_instr_responder.sv
// Randomized self-checking bench for l2_cfi_instr_responder (MEM_LATENCY=2).
module tb_l2_cfi_instr_responder;

    localparam int          LAT  = 2;
    localparam int          AW   = 14;
    localparam logic [31:0] BASE = 32'h1C00_0000;
    localparam longint      SPAN = 4 * (longint'(1) << AW);

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic [31:0] add_i = '0;
    logic        wen_i = 1'b1;
    logic [31:0] wdata_i = '0;
    logic [3:0]  be_i = '0;
    logic        gnt_o, r_valid_o, r_opc_o, mem_req_o;
    logic [31:0] r_rdata_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0] mem_rdata_i = '0;
    logic [15:0] err_cnt_o;

    l2_cfi_instr_responder #(
        .CFI_INSTR_WIDTH (32),
        .MEM_ADDR_WIDTH  (AW),
        .BASE_ADDR       (BASE),
        .MEM_LATENCY     (LAT)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .add_i       (add_i),
        .wen_i       (wen_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .r_valid_o   (r_valid_o),
        .r_rdata_o   (r_rdata_o),
        .r_opc_o     (r_opc_o),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .err_cnt_o   (err_cnt_o)
    );

    always #5 clk = ~clk;

    // SRAM contents and a two-cycle read pipe standing in for the macro.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] sram_s1 = '0;
    always @(posedge clk) begin
        sram_s1     <= mem_req_o ? mem[mem_addr_o] : $urandom;
        mem_rdata_i <= sram_s1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] data;
    } exp_t;
    exp_t expq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    int deny_run = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        longint la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + SPAN);
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    // Compare every DUT output for the current cycle, then advance the model.
    task automatic check_cycle();
        bit   g, ok, emit_err;
        exp_t e;
`ifdef L2_RESP_STALL_EN
        g = gnt_o;
        if (req_i && !gnt_o) deny_run++;
        else                 deny_run = 0;
        check("max_denials", 32'(deny_run > 3), 32'd0);
        check("gnt_needs_req", 32'(gnt_o & ~req_i), 32'd0);
`else
        g = req_i;
        check("gnt", 32'(gnt_o), 32'(g));
`endif
        ok = in_range(add_i) && wen_i;
        check("mem_req", 32'(mem_req_o), 32'(g & ok));
        if (g && ok) check("mem_addr", 32'(mem_addr_o), 32'(word_idx(add_i)));

        emit_err = 1'b0;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            check("r_valid", 32'(r_valid_o), 32'd1);
            check("r_opc", 32'(r_opc_o), 32'(e.err));
            check("r_rdata", r_rdata_o, e.data);
            emit_err = e.err;
        end else begin
            check("r_valid_idle", 32'(r_valid_o), 32'd0);
            check("r_opc_idle", 32'(r_opc_o), 32'd0);
            check("r_rdata_idle", r_rdata_o, 32'd0);
        end
        check("err_cnt", 32'(err_cnt_o), 32'(exp_cnt));
        if (emit_err && exp_cnt < 16'hFFFF) exp_cnt++;

        if (g) begin
            e.due  = cyc + LAT;
            e.err  = !ok;
            e.data = ok ? mem[word_idx(add_i)] : 32'd0;
            expq.push_back(e);
        end
    endtask

    task automatic step(input bit rq, input logic [31:0] a, input bit we);
        @(posedge clk);
        #1;
        req_i   = rq;
        add_i   = a;
        wen_i   = we;
        wdata_i = $urandom;
        be_i    = 4'($urandom);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, 32'(gnt_o), 32'd0);
        check({tag, "_r_valid"}, 32'(r_valid_o), 32'd0);
        check({tag, "_r_rdata"}, r_rdata_o, 32'd0);
        check({tag, "_r_opc"}, 32'(r_opc_o), 32'd0);
        check({tag, "_mem_req"}, 32'(mem_req_o), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr_o), 32'd0);
        check({tag, "_err_cnt"}, 32'(err_cnt_o), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 6))
            0, 1, 2: return BASE + ($urandom_range(0, (1 << AW) - 1) << 2) + $urandom_range(0, 3);
            3:       return BASE - 32'($urandom_range(1, 64));
            4:       return BASE + 32'(SPAN) + 32'($urandom_range(0, 64));
            5:       return BASE + 32'(SPAN) - 32'($urandom_range(1, 4));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[4] = 32'hDEAD_BEEF;

        // Reset with a request pending: grant must stay low.
        repeat (3) @(posedge clk);
        #1;
        req_i = 1'b1;
        add_i = BASE;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        req_i = 1'b0;
        rst_i = 1'b0;

        // Single read returning DEAD_BEEF from word 4.
        step(1'b1, 32'h1C00_0010, 1'b1);
        check("deadbeef_addr", 32'(mem_addr_o), 32'd4);
        idle(1);
        step(1'b0, 32'h0, 1'b1);
        check("deadbeef_data", r_rdata_o, 32'hDEAD_BEEF);
        idle(2);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) step(1'b1, BASE + 32'(4 * i), 1'b1);
        idle(LAT + 1);

        // Below range, above range, in-range write.
        step(1'b1, 32'h1BFF_FFFC, 1'b1);
        step(1'b1, 32'h1C01_0000, 1'b1);
        step(1'b1, 32'h1C00_0000, 1'b0);
        idle(LAT + 1);
        check("err_cnt_three", 32'(err_cnt_o), 32'd3);

        // Good / bad / good.
        step(1'b1, BASE + 32'h20, 1'b1);
        step(1'b1, BASE + 32'(SPAN), 1'b1);
        step(1'b1, BASE + 32'(SPAN) - 32'd4, 1'b1);
        idle(LAT + 1);

        // Reset with two responses in flight.
        step(1'b1, BASE + 32'h40, 1'b1);
        step(1'b1, BASE + 32'h44, 1'b1);
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        req_i = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        expq.delete();
        exp_cnt  = 0;
        deny_run = 0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle(LAT + 2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 7), rand_addr(), ($urandom_range(0, 9) < 8));
        idle(LAT + 1);

`ifdef L2_RESP_STALL_EN
        for (int i = 0; i < 200; i++) step(1'b1, BASE + 32'(4 * (i % 64)), 1'b1);
        idle(LAT + 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
